// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decode-side bus into the next-PC controller.
// ALIGN_CHECK_EN adds the misalign_trap signal.
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = 32,
    parameter int COUNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]    start_pc;
    logic [PC_WIDTH-1:0]    cur_pc;
    logic                   branch_taken;
    logic [15:0]            branch_offset;
    logic                   jump;
    logic [25:0]            jump_index;
    logic                   jump_reg;
    logic [PC_WIDTH-1:0]    reg_target;
    logic                   stall_req;
    logic                   halt_instr;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   pc_valid;
    logic                   halted;
    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] instr_count;
`ifdef ALIGN_CHECK_EN
    logic                   misalign_trap;
`endif

    modport master (
        output start_pc, cur_pc, branch_taken, branch_offset, jump, jump_index,
               jump_reg, reg_target, stall_req, halt_instr,
`ifdef ALIGN_CHECK_EN
        input  misalign_trap,
`endif
        input  next_pc, pc_valid, halted, state, instr_count
    );

    modport slave (
        input  start_pc, cur_pc, branch_taken, branch_offset, jump, jump_index,
               jump_reg, reg_target, stall_req, halt_instr,
`ifdef ALIGN_CHECK_EN
        output misalign_trap,
`endif
        output next_pc, pc_valid, halted, state, instr_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller (boot/run/stall/halt, branch/jump/JR targets, advance counter).
// Defining ALIGN_CHECK_EN redirects misaligned JR targets to TRAP_VECTOR and drives misalign_trap.
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  BOOT_CYCLES = 2,
    parameter int                  COUNT_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(32'h0000_0180)
) (
    input logic         clk,
    input logic         reset,
    pc_sequencer_if.slave bus
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, HALT = 2'd3} state_t;

    state_t               st, st_nx;
    logic [BW-1:0]        boot_cnt;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [PC_WIDTH-1:0]  pc4, br_tgt, j_tgt, npc;
    logic                 boot_done, adv, misalign;

    assign pc4       = bus.cur_pc + PC_WIDTH'(4);
    assign br_tgt    = pc4 + {{(PC_WIDTH-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
    assign j_tgt     = {pc4[PC_WIDTH-1:28], bus.jump_index, 2'b00};
    assign boot_done = (BOOT_CYCLES <= 1) || (int'(boot_cnt) == BOOT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= BOOT;
            boot_cnt <= '0;
            cnt      <= '0;
        end else begin
            st       <= st_nx;
            boot_cnt <= (st == BOOT) ? boot_cnt + 1'b1 : boot_cnt;
            cnt      <= adv ? cnt + 1'b1 : cnt;
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            BOOT:    st_nx = boot_done ? RUN : BOOT;
            RUN:     st_nx = bus.halt_instr ? HALT : bus.stall_req ? STALL : RUN;
            STALL:   st_nx = bus.stall_req ? STALL : RUN;
            default: st_nx = HALT;
        endcase
    end

    // Halt outranks stall, and both hold the PC without counting an advance.
    always_comb begin
        adv      = (st == RUN) && !bus.halt_instr && !bus.stall_req;
        misalign = ALIGN && adv && bus.jump_reg && (bus.reg_target[1:0] != 2'b00);
        npc      = (st == BOOT)     ? bus.start_pc :
                   !adv             ? bus.cur_pc   :
                   misalign         ? TRAP_VECTOR  :
                   bus.jump_reg     ? bus.reg_target :
                   bus.jump         ? j_tgt        :
                   bus.branch_taken ? br_tgt       : pc4;
    end

    assign bus.next_pc     = npc;
    assign bus.pc_valid    = (st == RUN);
    assign bus.halted      = (st == HALT);
    assign bus.state       = st;
    assign bus.instr_count = cnt;
`ifdef ALIGN_CHECK_EN
    assign bus.misalign_trap = misalign;
`endif
endmodule
